w_lms_serial: RTL and testbench

//  Parametrised adaptive FIR (W filter) with in-block LMS coefficient update; successor to fixed-size w_test.
//  Per accepted reference sample: update w by mu*e*x_old, then y = sum(w*x_new), all serialised over N cycles.

---
 rtl/w_lms_serial.sv | 149 ++++++++++++++
 tb/tb_w_lms_serial.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/w_lms_serial.sv
// Serial adaptive FIR with in-block LMS update: one tap per cycle, two multipliers.
// Optional leakage on the coefficient update is enabled by defining W_LEAKAGE_EN.
module w_lms_serial #(
    parameter int N       = 32,
    parameter int IN_W    = 32,
    parameter int R_IN    = 31,
    parameter int COEF_W  = 32,
    parameter int R_W     = 30,
    parameter int OUT_W   = 32,
    parameter int R_OUT   = 31,
    parameter int MU_SH   = 8,
    parameter int LEAK_SH = 12
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    valid_u_in,
    input  logic signed [IN_W-1:0]  data_u_in,
    input  logic                    valid_lms_in,
    input  logic signed [IN_W-1:0]  data_lms_in,
    input  logic                    adapt_en,
    output logic signed [OUT_W-1:0] data_out,
    output logic                    valid_out,
    output logic                    busy,
    output logic                    overrun
);
    localparam int KW    = $clog2(N);
    localparam int PE_W  = 2 * IN_W;
    localparam int SUM_W = ((PE_W > COEF_W) ? PE_W : COEF_W) + 2;
    localparam int PY_W  = COEF_W + IN_W;
    localparam int ACC_W = IN_W + COEF_W + $clog2(N);
    localparam int SH_D  = 2 * R_IN - R_W + MU_SH;
    localparam int SH_O  = R_IN + R_W - R_OUT;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OUT = 2'd2} state_t;

    state_t                    state_r;
    logic [KW-1:0]             k_r;
    logic signed [IN_W-1:0]    x_r [N];
    logic signed [COEF_W-1:0]  w_r [N];
    logic signed [IN_W-1:0]    u_r, e_reg_r, e_use_r;
    logic signed [ACC_W-1:0]   acc_r;
    logic signed [OUT_W-1:0]   data_out_r;
    logic                      valid_out_r, busy_r, overrun_r;

    logic [KW-1:0]             k_prev_s;
    logic signed [IN_W-1:0]    x_old_s, x_new_s;
    logic signed [PE_W-1:0]    prod_e_s, delta_s;
    logic signed [SUM_W-1:0]   w_ext_s, leak_s, sum_s;
    logic signed [COEF_W-1:0]  w_n_s;
    logic signed [PY_W-1:0]    prod_y_s;
    logic signed [ACC_W-1:0]   acc_sh_s;

    function automatic logic signed [COEF_W-1:0] sat_coef(input logic signed [SUM_W-1:0] v);
        logic [SUM_W-COEF_W:0] top;
        top = v[SUM_W-1:COEF_W-1];
        if ((&top) || !(|top)) sat_coef = v[COEF_W-1:0];
        else if (v[SUM_W-1])   sat_coef = {1'b1, {(COEF_W-1){1'b0}}};
        else                   sat_coef = {1'b0, {(COEF_W-1){1'b1}}};
    endfunction

    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
        logic [ACC_W-OUT_W:0] top;
        top = v[ACC_W-1:OUT_W-1];
        if ((&top) || !(|top)) sat_out = v[OUT_W-1:0];
        else if (v[ACC_W-1])   sat_out = {1'b1, {(OUT_W-1){1'b0}}};
        else                   sat_out = {1'b0, {(OUT_W-1){1'b1}}};
    endfunction

    // Per-tap datapath: coefficient update from the old sample, then MAC with the new one.
    always_comb begin
        k_prev_s = k_r - KW'(1);
        x_old_s  = x_r[k_r];
        if (k_r == {KW{1'b0}}) x_new_s = u_r;
        else                   x_new_s = x_r[k_prev_s];
        prod_e_s = e_use_r * x_old_s;
        delta_s  = prod_e_s >>> SH_D;
        w_ext_s  = SUM_W'(w_r[k_r]);
`ifdef W_LEAKAGE_EN
        leak_s   = w_ext_s >>> LEAK_SH;
`else
        leak_s   = {SUM_W{1'b0}};
`endif
        sum_s    = w_ext_s - leak_s + SUM_W'(delta_s);
        if (adapt_en) w_n_s = sat_coef(sum_s);
        else          w_n_s = w_r[k_r];
        prod_y_s = w_n_s * x_new_s;
        acc_sh_s = acc_r >>> SH_O;
    end

    // Control FSM, tap/coefficient storage and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            k_r         <= {KW{1'b0}};
            u_r         <= {IN_W{1'b0}};
            e_reg_r     <= {IN_W{1'b0}};
            e_use_r     <= {IN_W{1'b0}};
            acc_r       <= {ACC_W{1'b0}};
            data_out_r  <= {OUT_W{1'b0}};
            valid_out_r <= 1'b0;
            busy_r      <= 1'b0;
            overrun_r   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                x_r[i] <= {IN_W{1'b0}};
                w_r[i] <= {COEF_W{1'b0}};
            end
        end else begin
            valid_out_r <= 1'b0;
            if (valid_lms_in) e_reg_r <= data_lms_in;
            case (state_r)
                IDLE: begin
                    if (valid_u_in) begin
                        u_r     <= data_u_in;
                        e_use_r <= valid_lms_in ? data_lms_in : e_reg_r;
                        acc_r   <= {ACC_W{1'b0}};
                        k_r     <= KW'(N - 1);
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    // Descending k keeps x[k-1] at its old value when tap k shifts it in.
                    x_r[k_r] <= x_new_s;
                    w_r[k_r] <= w_n_s;
                    acc_r    <= acc_r + ACC_W'(prod_y_s);
                    if (valid_u_in) overrun_r <= 1'b1;
                    if (k_r == {KW{1'b0}}) state_r <= OUT;
                    else                   k_r     <= k_prev_s;
                end
                OUT: begin
                    data_out_r  <= sat_out(acc_sh_s);
                    valid_out_r <= 1'b1;
                    busy_r      <= 1'b0;
                    if (valid_u_in) overrun_r <= 1'b1;
                    state_r     <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out  = data_out_r;
    assign valid_out = valid_out_r;
    assign busy      = busy_r;
    assign overrun   = overrun_r;
endmodule

// File: tb/tb_w_lms_serial.sv
// Directed self-checking bench for w_lms_serial in the small N=4, Q15 configuration.
module tb_w_lms_serial;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int WIN = 2 * N + 6;

    logic                clock = 1'b0;
    logic                reset;
    logic                valid_u_in, valid_lms_in, adapt_en;
    logic signed [W-1:0] data_u_in, data_lms_in;
    logic signed [W-1:0] data_out;
    logic                valid_out, busy, overrun;

    int total = 0;
    int bad   = 0;
    int lat, nv;
    logic busy1;

    w_lms_serial #(
        .N(4), .IN_W(16), .R_IN(15), .COEF_W(16), .R_W(15),
        .OUT_W(16), .R_OUT(15), .MU_SH(0), .LEAK_SH(12)
    ) dut (
        .clock(clock), .reset(reset),
        .valid_u_in(valid_u_in), .data_u_in(data_u_in),
        .valid_lms_in(valid_lms_in), .data_lms_in(data_lms_in),
        .adapt_en(adapt_en),
        .data_out(data_out), .valid_out(valid_out),
        .busy(busy), .overrun(overrun)
    );

    always #5 clock = ~clock;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Offer one sample, then watch a fixed window; optionally inject an extra
    // valid_u_in or a reset pulse sampled on edge ov_at / rst_at after the accept.
    task automatic run_sample(input logic [W-1:0] u, input logic with_e, input logic [W-1:0] e,
                              input int ov_at, input logic [W-1:0] ov_u, input int rst_at,
                              output int lat_o, output int nv_o, output logic busy_o);
        valid_u_in   = 1'b1;
        data_u_in    = u;
        valid_lms_in = with_e;
        data_lms_in  = e;
        @(posedge clock);
        #1;
        valid_u_in   = 1'b0;
        valid_lms_in = 1'b0;
        lat_o  = 0;
        nv_o   = 0;
        busy_o = busy;
        for (int c = 1; c <= WIN; c++) begin
            if (c == ov_at) begin
                valid_u_in = 1'b1;
                data_u_in  = ov_u;
            end
            if (c == rst_at) reset = 1'b1;
            @(posedge clock);
            #1;
            valid_u_in = 1'b0;
            reset      = 1'b0;
            if (valid_out) begin
                nv_o++;
                if (lat_o == 0) lat_o = c;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        valid_u_in = 1'b0; valid_lms_in = 1'b0; adapt_en = 1'b0;
        data_u_in = 16'sd0; data_lms_in = 16'sd0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk_eq("rst_data_out", 32'(data_out), 32'h0);
        chk_eq("rst_valid_out", 32'(valid_out), 32'h0);
        chk_eq("rst_busy", 32'(busy), 32'h0);
        chk_eq("rst_overrun", 32'(overrun), 32'h0);

        // Frozen, zero coefficients: output 0 on the (N+1)th edge after accept.
        adapt_en = 1'b0;
        run_sample(16'h4000, 1'b0, 16'h0, 0, 16'h0, 0, lat, nv, busy1);
        chk_eq("frz_latency", 32'(lat), 32'(N + 1));
        chk_eq("frz_nvalid", 32'(nv), 32'd1);
        chk_eq("frz_y", 32'(data_out), 32'h0);
        chk_eq("frz_busy", 32'(busy1), 32'd1);

        // Adapt with e=0.5: first y=0, second w[0]=0.25 -> y=0.125.
        reset_dut();
        adapt_en = 1'b1;
        run_sample(16'h4000, 1'b1, 16'h4000, 0, 16'h0, 0, lat, nv, busy1);
        chk_eq("adp_y1", 32'(data_out), 32'h0);
        run_sample(16'h4000, 1'b0, 16'h0, 0, 16'h0, 0, lat, nv, busy1);
        chk_eq("adp_y2", 32'(data_out), 32'h1000);
        chk_eq("adp_latency", 32'(lat), 32'(N + 1));

        // Overrun: w[0]=0x2000 frozen, u=0x2000 -> y=0x0800; intruding sample dropped.
        adapt_en = 1'b0;
        run_sample(16'h2000, 1'b0, 16'h0, 3, 16'h7FFF, 0, lat, nv, busy1);
        chk_eq("ovr_y", 32'(data_out), 32'h0800);
        chk_eq("ovr_nvalid", 32'(nv), 32'd1);
        chk_eq("ovr_flag", 32'(overrun), 32'd1);
        chk_eq("ovr_busy_after", 32'(busy), 32'd0);
        run_sample(16'h4000, 1'b0, 16'h0, 0, 16'h0, 0, lat, nv, busy1);
        chk_eq("ovr_y_next", 32'(data_out), 32'h1000);
        chk_eq("ovr_sticky", 32'(overrun), 32'd1);

        // Reset in RUN: pass aborted, everything back to reset values.
        run_sample(16'h7FFF, 1'b0, 16'h0, 0, 16'h0, 2, lat, nv, busy1);
        chk_eq("rrun_nvalid", 32'(nv), 32'd0);
        chk_eq("rrun_data_out", 32'(data_out), 32'h0);
        chk_eq("rrun_overrun", 32'(overrun), 32'd0);
        chk_eq("rrun_busy", 32'(busy), 32'd0);

        // Same-cycle error (e_reg=0 after reset) must drive the update.
        adapt_en = 1'b1;
        run_sample(16'h4000, 1'b0, 16'h0, 0, 16'h0, 0, lat, nv, busy1);
        chk_eq("same_y1", 32'(data_out), 32'h0);
        run_sample(16'h4000, 1'b1, 16'h4000, 0, 16'h0, 0, lat, nv, busy1);
        chk_eq("same_y2", 32'(data_out), 32'h1000);

        // Saturation: coefficients and output clamp at max, never wrap negative.
        reset_dut();
        for (int s = 0; s < 10; s++) begin
            run_sample(16'h7FFF, (s == 0), 16'h7FFF, 0, 16'h0, 0, lat, nv, busy1);
            chk_eq($sformatf("sat_sign%0d", s), 32'(data_out[W-1]), 32'd0);
        end
        chk_eq("sat_y", 32'(data_out), 32'h7FFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
